// File: rtl/eth_pkg.sv
// eth_pkg: shared types and constants for the kart Ethernet link.
// Payload field positions are shared with the receive decoder.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    HEADER,
    PAYLOAD,
    PAD,
    FCS,
    IFG
  } tx_state_t;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Preamble field count includes the SFD byte.
  localparam int PREAMBLE_BYTES = 8;
  localparam int HEADER_BYTES   = 14;
  localparam int PAYLOAD_BYTES  = 6;
  localparam int PAD_BYTES      = 40;
  localparam int FCS_BYTES      = 4;

  localparam int PAYLOAD_W = 48;

  localparam int X_MSB    = 43;
  localparam int X_LSB    = 33;
  localparam int Y_MSB    = 31;
  localparam int Y_LSB    = 21;
  localparam int DIR_MSB  = 19;
  localparam int DIR_LSB  = 11;
  localparam int GAME_MSB = 7;
  localparam int GAME_LSB = 5;
  localparam int RST_BIT  = 3;

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [8:0]  dir;
    logic [2:0]  game;
    logic        rst;
  } snap_t;

  function automatic logic [PAYLOAD_W-1:0] pack_payload(
    input snap_t s
  );
    logic [PAYLOAD_W-1:0] p;
    p = '0;
    p[X_MSB:X_LSB]       = s.x;
    p[Y_MSB:Y_LSB]       = s.y;
    p[DIR_MSB:DIR_LSB]   = s.dir;
    p[GAME_MSB:GAME_LSB] = s.game;
    p[RST_BIT]           = s.rst;
    return p;
  endfunction

endpackage

// File: rtl/game_state_tx_crc32_dibit.sv
// crc32_dibit: next reflected CRC-32 after shifting in one dibit.
// Bit 0 of the dibit enters first, matching RMII wire order.
module crc32_dibit
  import eth_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [1:0]  dibit,
  output logic [31:0] crc_next
);

  logic [31:0] crc_mid;

  assign crc_mid =
    {1'b0, crc[31:1]} ^
    ({32{crc[0] ^ dibit[0]}} & CRC_POLY);

  assign crc_next =
    {1'b0, crc_mid[31:1]} ^
    ({32{crc_mid[0] ^ dibit[1]}} & CRC_POLY);

endmodule

// File: rtl/game_state_tx.sv
// game_state_tx: RMII framer that sends the local kart state on request.
// Define GAME_STATE_TX_FCS_EN to append a CRC-32 FCS after the pad.
module game_state_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] DEST_MAC  = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC   = 48'h0200_0000_0001,
  parameter logic [15:0] ETHERTYPE = 16'h88B5,
  parameter int          IFG_BYTES = 12
) (
  input  logic        eth_clk,
  input  logic        eth_rstn,
  input  logic        send,
  input  logic [10:0] player_x,
  input  logic [10:0] player_y,
  input  logic [8:0]  direction,
  input  logic [2:0]  game_stat,
  input  logic        reset_req,
  output logic        busy,
  output logic        frame_done,
  output logic        eth_txen,
  output logic [1:0]  eth_txd
);

  localparam logic [111:0] HDR =
    {DEST_MAC, SRC_MAC, ETHERTYPE};

  localparam logic [5:0] PRE_LAST =
    6'(PREAMBLE_BYTES - 1);
  localparam logic [5:0] HDR_LAST =
    6'(HEADER_BYTES - 1);
  localparam logic [5:0] PAY_LAST =
    6'(PAYLOAD_BYTES - 1);
  localparam logic [5:0] PAD_LAST =
    6'(PAD_BYTES - 1);
  localparam logic [5:0] FCS_LAST =
    6'(FCS_BYTES - 1);
  localparam logic [5:0] IFG_LAST =
    6'(IFG_BYTES - 1);

  tx_state_t state;
  tx_state_t state_nxt;

  logic [1:0]  dib_cnt;
  logic [5:0]  byte_cnt;
  logic [5:0]  last_byte;
  logic        field_last;
  logic        start;

  snap_t       live_snap;
  snap_t       cur_snap;
  snap_t       pend_snap;
  logic        pending;

  logic [47:0] payload;
  logic [7:0]  hdr_byte;
  logic [7:0]  pay_byte;
  logic [7:0]  tx_byte;
  logic [1:0]  data_dibit;
  logic [1:0]  fcs_dibit;
  logic        txen_nxt;
  logic [1:0]  txd_nxt;

  assign live_snap = {
    player_x,
    player_y,
    direction,
    game_stat,
    reset_req
  };

  assign payload = pack_payload(cur_snap);

  always_comb begin
    last_byte = '0;
    unique case (state)
      PREAMBLE: last_byte = PRE_LAST;
      HEADER:   last_byte = HDR_LAST;
      PAYLOAD:  last_byte = PAY_LAST;
      PAD:      last_byte = PAD_LAST;
      FCS:      last_byte = FCS_LAST;
      IFG:      last_byte = IFG_LAST;
      default:  last_byte = '0;
    endcase
  end

  assign field_last =
    (dib_cnt == 2'd3) &&
    (byte_cnt == last_byte);

  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (send) state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        if (field_last) state_nxt = HEADER;
      end
      HEADER: begin
        if (field_last) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        if (field_last) state_nxt = PAD;
      end
      PAD: begin
`ifdef GAME_STATE_TX_FCS_EN
        if (field_last) state_nxt = FCS;
`else
        if (field_last) state_nxt = IFG;
`endif
      end
      FCS: begin
        if (field_last) state_nxt = IFG;
      end
      IFG: begin
        // Back-to-back: a queued or same-cycle request skips IDLE.
        if (field_last) begin
          state_nxt = (send || pending) ?
                      PREAMBLE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign start =
    (state_nxt == PREAMBLE) &&
    (state != PREAMBLE);

  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      dib_cnt  <= '0;
      byte_cnt <= '0;
    end else if (state_nxt != state ||
                 state == IDLE) begin
      dib_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      dib_cnt <= dib_cnt + 2'd1;
      if (dib_cnt == 2'd3) begin
        byte_cnt <= byte_cnt + 6'd1;
      end
    end
  end

  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      cur_snap  <= '0;
      pend_snap <= '0;
      pending   <= 1'b0;
    end else if (start) begin
      cur_snap <= send ? live_snap : pend_snap;
      pending  <= 1'b0;
    end else if (send && state != IDLE) begin
      pend_snap <= live_snap;
      pending   <= 1'b1;
    end
  end

  assign hdr_byte =
    8'(HDR >> {6'd13 - byte_cnt, 3'b000});
  assign pay_byte =
    8'(payload >> {6'd5 - byte_cnt, 3'b000});

  always_comb begin
    tx_byte  = '0;
    txen_nxt = 1'b0;
    unique case (1'b1)
      (state == PREAMBLE): begin
        txen_nxt = 1'b1;
        tx_byte  = (byte_cnt == PRE_LAST) ?
                   SFD_BYTE : PREAMBLE_BYTE;
      end
      (state == HEADER): begin
        txen_nxt = 1'b1;
        tx_byte  = hdr_byte;
      end
      (state == PAYLOAD): begin
        txen_nxt = 1'b1;
        tx_byte  = pay_byte;
      end
      (state == PAD): begin
        txen_nxt = 1'b1;
      end
      (state == FCS): begin
        txen_nxt = 1'b1;
      end
      default: begin
        txen_nxt = 1'b0;
      end
    endcase
  end

  assign data_dibit =
    2'(tx_byte >> {dib_cnt, 1'b0});

  assign txd_nxt =
    !txen_nxt         ? 2'b00 :
    (state == FCS)    ? fcs_dibit :
                        data_dibit;

  assign busy       = (state != IDLE);
  assign frame_done = (state == IFG) && field_last;

`ifdef GAME_STATE_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] crc_nxt;

  crc32_dibit u_crc (
    .crc      (crc),
    .dibit    (data_dibit),
    .crc_next (crc_nxt)
  );

  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      crc <= CRC_INIT;
    end else if (state == PREAMBLE) begin
      crc <= CRC_INIT;
    end else if (state == HEADER ||
                 state == PAYLOAD ||
                 state == PAD) begin
      crc <= crc_nxt;
    end
  end

  // FCS goes out complemented, least significant dibit first.
  assign fcs_dibit =
    2'(~crc >> {byte_cnt[1:0], dib_cnt, 1'b0});
`else
  assign fcs_dibit = 2'b00;
`endif

  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      eth_txen <= 1'b0;
      eth_txd  <= 2'b00;
    end else begin
      eth_txen <= txen_nxt;
      eth_txd  <= txd_nxt;
    end
  end

endmodule
